// File: rtl/nvdla_eng_done_intr_gen_pkg.sv
// rtl/nvdla_eng_done_intr_gen_pkg.sv - shared types and defaults for the engine done-interrupt tracker
package nvdla_eng_done_intr_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } eng_state_e;

    localparam int NUM_GRP    = 2;
    localparam int DEF_BEAT_W = 20;
    localparam int DEF_OUTS_W = 8;

endpackage

// File: rtl/nvdla_done_outs_cnt.sv
// rtl/nvdla_done_outs_cnt.sv - saturating up/down counter of outstanding DMA writes
module nvdla_done_outs_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         ovf_err,
    output logic         unf_err
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    // An accept and a response in the same cycle cancel; flag moves past either end
    always_comb begin
        ovf_err = inc & ~dec & (cnt == CNT_MAX);
        unf_err = dec & ~inc & (cnt == '0);
    end

    // Count register; an out-of-range move leaves the value pinned at the rail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && !ovf_err) begin
            cnt <= cnt + CNT_ONE;
        end else if (dec && !inc && !unf_err) begin
            cnt <= cnt - CNT_ONE;
        end
    end

endmodule

// File: rtl/nvdla_eng_done_intr_gen.sv
// rtl/nvdla_eng_done_intr_gen.sv - per-engine layer completion tracker and done-interrupt generator
module nvdla_eng_done_intr_gen
    import nvdla_eng_done_intr_gen_pkg::*;
#(
    parameter int BEAT_W = DEF_BEAT_W,
    parameter int OUTS_W = DEF_OUTS_W
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic [NUM_GRP-1:0]   reg2dp_op_en,
    input  logic [BEAT_W-1:0]    reg2dp_beat_num_g0,
    input  logic [BEAT_W-1:0]    reg2dp_beat_num_g1,
    input  logic                 beat_vld,
    input  logic                 beat_rdy,
    input  logic                 wr_req_accept,
    input  logic                 wr_rsp,
    output logic                 dp2reg_consumer,
    output logic [NUM_GRP-1:0]   dp2reg_done,
    output logic [NUM_GRP-1:0]   done_intr_pd,
    output logic                 op_busy,
    output logic                 proto_err
);

    localparam logic [BEAT_W-1:0] BEAT_ONE = {{(BEAT_W-1){1'b0}}, 1'b1};

    eng_state_e          state_q;
    eng_state_e          state_d;
    logic                consumer_q;
    logic [BEAT_W-1:0]   beat_cnt_q;
    logic                proto_err_q;
    logic [OUTS_W-1:0]   outs_cnt;
    logic                outs_ovf;
    logic                outs_unf;
    logic                beat_hs;
    logic [BEAT_W-1:0]   beat_num_cur;
    logic                last_beat;

    assign beat_hs      = beat_vld & beat_rdy;
    assign beat_num_cur = consumer_q ? reg2dp_beat_num_g1 : reg2dp_beat_num_g0;
    assign last_beat    = beat_hs && (beat_cnt_q == beat_num_cur);

    nvdla_done_outs_cnt #(
        .W (OUTS_W)
    ) u_outs (
        .clk     (nvdla_core_clk),
        .rst_n   (nvdla_core_rstn),
        .inc     (wr_req_accept),
        .dec     (wr_rsp),
        .cnt     (outs_cnt),
        .ovf_err (outs_ovf),
        .unf_err (outs_unf)
    );

    // State register
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: arm on op_en, count beats, wait for writes to drain, one-cycle done
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (reg2dp_op_en[consumer_q]) state_d = ST_RUN;
            ST_RUN:   if (last_beat) state_d = ST_DRAIN;
            ST_DRAIN: if ((outs_cnt == '0) && !wr_req_accept) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Beat counter, consumer pointer and sticky protocol error
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            beat_cnt_q  <= '0;
            consumer_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && reg2dp_op_en[consumer_q]) begin
                beat_cnt_q <= '0;
            end else if (state_q == ST_RUN && beat_hs && !last_beat) begin
                beat_cnt_q <= beat_cnt_q + BEAT_ONE;
            end
            if (state_q == ST_DONE) begin
                consumer_q <= ~consumer_q;
            end
            if ((beat_hs && state_q != ST_RUN) || outs_ovf || outs_unf) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // Outputs decoded from registered state only, so pulses are glitch-free
    always_comb begin
        op_busy         = (state_q != ST_IDLE);
        dp2reg_consumer = consumer_q;
        proto_err       = proto_err_q;
        done_intr_pd    = '0;
        dp2reg_done     = '0;
        if (state_q == ST_DONE) begin
            done_intr_pd = consumer_q ? 2'b10 : 2'b01;
            dp2reg_done  = consumer_q ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: tb/tb_nvdla_eng_done_intr_gen.sv
// tb/tb_nvdla_eng_done_intr_gen.sv - self-checking bench for the engine done-interrupt tracker
module tb_nvdla_eng_done_intr_gen;

    logic        clk;
    logic        rst_n;
    logic [1:0]  op_en;
    logic [19:0] bn0;
    logic [19:0] bn1;
    logic        vld;
    logic        rdy;
    logic        acc;
    logic        rsp;
    logic        cons;
    logic [1:0]  done;
    logic [1:0]  intr;
    logic        busy;
    logic        perr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_pulse_cyc = -1;
    int last_pulse_val = 0;
    int pulse_q[$];
    int pulse_cyc_q[$];

    // reference model: phase 0 idle, 1 run, 2 drain, 3 done
    int m_phase;
    int m_cons;
    int m_left;
    int m_outs;
    int m_err;

    nvdla_eng_done_intr_gen dut (
        .nvdla_core_clk     (clk),
        .nvdla_core_rstn    (rst_n),
        .reg2dp_op_en       (op_en),
        .reg2dp_beat_num_g0 (bn0),
        .reg2dp_beat_num_g1 (bn1),
        .beat_vld           (vld),
        .beat_rdy           (rdy),
        .wr_req_accept      (acc),
        .wr_rsp             (rsp),
        .dp2reg_consumer    (cons),
        .dp2reg_done        (done),
        .done_intr_pd       (intr),
        .op_busy            (busy),
        .proto_err          (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_cons  = 0;
        m_left  = 0;
        m_outs  = 0;
        m_err   = 0;
    endtask

    task automatic model_step();
        int o;
        bit hs;
        o  = m_outs;
        hs = vld && rdy;
        if (hs && m_phase != 1) m_err = 1;
        if (acc && !rsp) begin
            if (o == 255) m_err = 1; else m_outs = o + 1;
        end else if (rsp && !acc) begin
            if (o == 0) m_err = 1; else m_outs = o - 1;
        end
        case (m_phase)
            0: if (op_en[m_cons]) begin
                   m_phase = 1;
                   m_left  = (m_cons != 0 ? int'(bn1) : int'(bn0)) + 1;
               end
            1: if (hs) begin
                   m_left--;
                   if (m_left == 0) m_phase = 2;
               end
            2: if (o == 0 && !acc) m_phase = 3;
            default: begin
                   m_phase = 0;
                   m_cons  = 1 - m_cons;
               end
        endcase
    endtask

    task automatic check_all();
        int exp_pd;
        exp_pd = (m_phase == 3) ? (m_cons != 0 ? 2 : 1) : 0;
        chk("op_busy", int'(busy), (m_phase != 0) ? 1 : 0);
        chk("consumer", int'(cons), m_cons);
        chk("done_intr_pd", int'(intr), exp_pd);
        chk("dp2reg_done", int'(done), exp_pd);
        chk("proto_err", int'(perr), m_err);
        chk("outs_cnt", int'(dut.u_outs.cnt), m_outs);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check_all();
        if (intr != 2'b00) begin
            last_pulse_cyc = cyc;
            last_pulse_val = int'(intr);
            pulse_q.push_back(int'(intr));
            pulse_cyc_q.push_back(cyc);
        end
    endtask

    task automatic clear_inputs();
        op_en = 2'b00;
        vld   = 1'b0;
        rdy   = 1'b0;
        acc   = 1'b0;
        rsp   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        pulse_q.delete();
        pulse_cyc_q.delete();
        check_all();
    endtask

    initial begin
        int c0;
        int t;
        bn0 = '0;
        bn1 = '0;
        clear_inputs();
        rst_n = 1'b0;

        // reset state
        do_reset();

        // single layer, group 0, four beats: pulse 01 six cycles after op_en
        bn0 = 20'd3;
        op_en = 2'b01;
        c0 = cyc;
        tick();
        op_en = 2'b00;
        vld = 1'b1; rdy = 1'b1;
        repeat (4) tick();
        vld = 1'b0; rdy = 1'b0;
        repeat (4) tick();
        chk("single_pulse_cycle", last_pulse_cyc, c0 + 6);
        chk("single_pulse_value", last_pulse_val, 1);
        chk("single_pulse_count", pulse_q.size(), 1);
        chk("single_consumer", int'(cons), 1);

        // fastest layer on group 1: pulse three cycles after op_en
        bn1 = 20'd0;
        op_en = 2'b10;
        c0 = cyc;
        tick();
        op_en = 2'b00;
        vld = 1'b1; rdy = 1'b1;
        tick();
        vld = 1'b0; rdy = 1'b0;
        repeat (4) tick();
        chk("fast_pulse_cycle", last_pulse_cyc, c0 + 3);
        chk("fast_pulse_value", last_pulse_val, 2);
        chk("fast_consumer", int'(cons), 0);

        // ping-pong with both groups armed
        pulse_q.delete();
        pulse_cyc_q.delete();
        bn0 = 20'd1;
        bn1 = 20'd2;
        op_en = 2'b11;
        c0 = cyc;
        for (int i = 0; i < 40 && pulse_q.size() < 2; i++) begin
            vld = (m_phase == 1);
            rdy = (m_phase == 1);
            if (cons == 1'b1 && busy) op_en = 2'b00;
            tick();
        end
        vld = 1'b0; rdy = 1'b0; op_en = 2'b00;
        repeat (3) tick();
        chk("pingpong_pulse_count", pulse_q.size(), 2);
        if (pulse_q.size() == 2) begin
            chk("pingpong_first", pulse_q[0], 1);
            chk("pingpong_second", pulse_q[1], 2);
            chk("pingpong_first_cycle", pulse_cyc_q[0], c0 + 4);
            chk("pingpong_second_cycle", pulse_cyc_q[1], c0 + 10);
        end

        // drain: four writes outstanding, an extra accept during DRAIN
        pulse_q.delete();
        pulse_cyc_q.delete();
        acc = 1'b1;
        repeat (4) tick();
        acc = 1'b0;
        bn0 = 20'd0;
        op_en = 2'b01;
        tick();
        op_en = 2'b00;
        vld = 1'b1; rdy = 1'b1;
        tick();
        vld = 1'b0; rdy = 1'b0;
        repeat (5) tick();
        acc = 1'b1;
        tick();
        acc = 1'b0;
        repeat (4) tick();
        chk("drain_no_early_pulse", pulse_q.size(), 0);
        t = 0;
        for (int i = 0; i < 5; i++) begin
            rsp = 1'b1;
            t = cyc;
            tick();
        end
        rsp = 1'b0;
        repeat (4) tick();
        chk("drain_done_cycle", last_pulse_cyc, t + 2);
        chk("drain_pulse_value", last_pulse_val, 1);

        // simultaneous accept and response keep the count steady
        acc = 1'b1;
        repeat (2) tick();
        rsp = 1'b1;
        repeat (10) tick();
        acc = 1'b0;
        chk("simul_outs", int'(dut.u_outs.cnt), 2);
        chk("simul_no_err", int'(perr), 0);
        repeat (2) tick();
        rsp = 1'b0;
        tick();
        chk("simul_drained", int'(dut.u_outs.cnt), 0);

        // response with nothing outstanding
        do_reset();
        rsp = 1'b1;
        tick();
        rsp = 1'b0;
        chk("underflow_err", int'(perr), 1);
        chk("underflow_cnt", int'(dut.u_outs.cnt), 0);

        // saturation at 255
        do_reset();
        acc = 1'b1;
        repeat (255) tick();
        chk("sat_cnt_full", int'(dut.u_outs.cnt), 255);
        chk("sat_no_err_yet", int'(perr), 0);
        tick();
        acc = 1'b0;
        chk("sat_cnt_hold", int'(dut.u_outs.cnt), 255);
        chk("sat_err", int'(perr), 1);

        // beat handshake while idle
        do_reset();
        vld = 1'b1; rdy = 1'b1;
        tick();
        vld = 1'b0; rdy = 1'b0;
        chk("idle_beat_err", int'(perr), 1);

        // asynchronous reset mid-RUN, then clean restart on group 0
        do_reset();
        bn0 = 20'd5;
        op_en = 2'b01;
        tick();
        op_en = 2'b00;
        vld = 1'b1; rdy = 1'b1;
        repeat (2) tick();
        vld = 1'b0; rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_consumer", int'(cons), 0);
        chk("rst_intr", int'(intr), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(perr), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        pulse_q.delete();
        pulse_cyc_q.delete();
        bn0 = 20'd0;
        op_en = 2'b01;
        c0 = cyc;
        tick();
        op_en = 2'b00;
        vld = 1'b1; rdy = 1'b1;
        tick();
        vld = 1'b0; rdy = 1'b0;
        repeat (3) tick();
        chk("restart_pulse_cycle", last_pulse_cyc, c0 + 3);
        chk("restart_pulse_value", last_pulse_val, 1);
        chk("restart_pulse_count", pulse_q.size(), 1);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (m_phase == 0) begin
                bn0 = 20'($urandom_range(0, 3));
                bn1 = 20'($urandom_range(0, 3));
            end
            op_en = 2'($urandom_range(0, 3));
            vld   = ($urandom_range(0, 3) != 0);
            rdy   = ($urandom_range(0, 3) != 0);
            acc   = ($urandom_range(0, 3) == 0);
            rsp   = (m_outs > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            tick();
            chk("never_11", (intr == 2'b11) ? 1 : 0, 0);
        end
        clear_inputs();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nvdla_eng_done_intr_gen.md
# nvdla_eng_done_intr_gen

Per-engine layer-completion tracker that produces the 2-bit done-interrupt packet consumed by the global interrupt controller (the `*2glb_done_intr_pd` inputs). It is instantiated once per engine, such as SDP, CDP, PDP, BDMA, RUBIK, CDMA or CACC. It follows the engine's ping-pong register groups (0/1), counts output beats of the active group, and waits for outstanding DMA write responses to drain. It then pulses the interrupt bit for that group and clears the group's op_en.

## Interface
Parameters:
- BEAT_W, 20, width of per-group beat count.
- OUTS_W, 8, width of outstanding-write counter; maximum outstanding is 2^OUTS_W-1.

Ports:
- nvdla_core_clk  in  1  core clock; one clock domain only.
- nvdla_core_rstn  in  1  reset, asynchronous, active-low.
- reg2dp_op_en  in  2  per-group armed level from the register file.
- reg2dp_beat_num_g0  in  BEAT_W  group 0 beats minus one.
- reg2dp_beat_num_g1  in  BEAT_W  group 1 beats minus one.
- beat_vld  in  1  datapath output valid (observed only).
- beat_rdy  in  1  datapath output ready (observed only).
- wr_req_accept  in  1  one DMA write request accepted this cycle.
- wr_rsp  in  1  one DMA write completion this cycle.
- dp2reg_consumer  out  1  group currently being consumed; reset 0.
- dp2reg_done  out  2  one-cycle clear pulse for op_en of the finished group; reset 0.
- done_intr_pd  out  2  to glb; bit g pulses one cycle when group g completes; reset 0.
- op_busy  out  1  state != IDLE; reset 0.
- proto_err  out  1  sticky error flag, cleared by reset only; reset 0.

## Operation
- States are IDLE, RUN, DRAIN and DONE. Reset state is IDLE.
- IDLE: when reg2dp_op_en[consumer]=1, go to RUN and clear beat_cnt.
- RUN:
  - A beat is counted on beat_vld&beat_rdy.
  - A beat with beat_cnt==beat_num[consumer] goes to DRAIN; otherwise beat_cnt increments.
- DRAIN: when outs_cnt==0 and wr_req_accept==0, go to DONE.
- DONE:
  - Lasts exactly one cycle.
  - done_intr_pd[consumer]=1 and dp2reg_done[consumer]=1. Both are decoded from the registered state, so they are glitch-free.
  - consumer toggles at the end of the cycle; next state is IDLE.
- Outstanding counter, independent of state:
  - accept only: +1. rsp only: -1. Both or neither: unchanged.
  - accept at the maximum: saturates and sets proto_err.
  - rsp at zero: stays 0 and sets proto_err.
- Handshaked beats outside RUN are ignored and set proto_err.
- Dropping reg2dp_op_en during RUN or DRAIN has no effect; there is no software abort. Only reset aborts.
- Reset mid-operation returns every register to its reset value. No interrupt is emitted.
- done_intr_pd is never 2'b11. At most one bit is set per cycle.

## Timing
- op_en sampled in IDLE at cycle t gives RUN at t+1.
- Fastest layer (beat_num=0, no writes):
  - op_en at cycle 0.
  - Beat at cycle 1.
  - DRAIN at cycle 2.
  - DONE at cycle 3, with done_intr_pd pulse in cycle 3.
  - consumer flips at cycle 4; IDLE at cycle 4.
- Back-to-back layers: if op_en[other group] is already high, RUN resumes at cycle 5. Turnaround is two idle cycles.
- DRAIN exit lags the last wr_rsp by one cycle: rsp at t makes outs_cnt 0 at t+1, giving DONE at t+2.
- There is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - the state enum (IDLE/RUN/DRAIN/DONE),
  - the group-count constant (2),
  - the default BEAT_W and OUTS_W.
- Sub-module nvdla_done_outs_cnt: up/down saturating counter with overflow/underflow error outputs. The FSM, beat counter and consumer pointer stay in the top module.

## Test plan
- Single layer, group 0, beat_num=3, 4 beats, no writes: one pulse, done_intr_pd=2'b01 at cycle 6; consumer becomes 1.
- Ping-pong: both op_en high, beat_num_g0=1 and beat_num_g1=2 → pulses 01 then 10 with exactly two idle cycles between RUN periods.
- Drain: 4 accepts, last beat sent, rsps delayed 10 cycles with the last one at t → DONE at t+2; an accept in DRAIN extends the wait.
- Simultaneous accept and rsp every cycle: outs_cnt stays constant; no proto_err.
- Errors:
  - rsp with outs_cnt=0 → proto_err=1 and counter stays 0.
  - 255 accepts then 1 more → saturates at 255 and sets proto_err.
  - beat handshake in IDLE → sets proto_err.
- Reset asserted mid-RUN (beat_cnt=2) → all outputs 0 immediately (asynchronous); after release the engine restarts cleanly from group 0.
